// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sequencer sharing one combinational adder among NUM_REQ requesters.
// Optional macro ADDER_ARB_OVF_EN adds rsp_ovf, a registered signed-overflow flag for each result.
module adder_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0]         add_in0,
  output logic [DATA_WIDTH-1:0]         add_in1,
  input  logic [DATA_WIDTH-1:0]         add_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_sum,
  output logic [ID_WIDTH-1:0]           rsp_id
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                          rsp_ovf
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH:0]     cand;
  logic                  can_issue;
  logic                  grant_found;
  logic                  grant_active;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;

  // Issue is allowed into an empty slot, or when the held result leaves on this same edge.
  assign can_issue    = (state == EMPTY) | ((state == FULL) & rsp_ready);
  assign grant_active = can_issue & grant_found & ~rst;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_WIDTH+1)'(k);
      if (cand >= (ID_WIDTH+1)'(NUM_REQ))
        cand = cand - (ID_WIDTH+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_WIDTH'(i)) begin
        sel_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= EMPTY;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (grant_active) state_next = FULL;
      FULL:  if (rsp_ready && !grant_active) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Adder operands are forced to zero when nothing is granted so the shared adder sees a quiet input.
  always_comb begin
    rsp_valid = (state == FULL);
    req_ready = '0;
    add_in0   = '0;
    add_in1   = '0;
    if (grant_active) begin
      req_ready[grant_idx] = 1'b1;
      add_in0              = sel_a;
      add_in1              = sel_b;
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic ovf_now;
  assign ovf_now = (sel_a[DATA_WIDTH-1] == sel_b[DATA_WIDTH-1]) &&
                   (add_out[DATA_WIDTH-1] != sel_a[DATA_WIDTH-1]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      rsp_sum <= '0;
      rsp_id  <= '0;
`ifdef ADDER_ARB_OVF_EN
      rsp_ovf <= 1'b0;
`endif
    end else if (grant_active) begin
      rsp_sum <= add_out;
      rsp_id  <= grant_idx;
      ptr     <= (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + ID_WIDTH'(1);
`ifdef ADDER_ARB_OVF_EN
      rsp_ovf <= ovf_now;
`endif
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter with a behavioural adder on add_in0/add_in1.
// Build with ADDER_ARB_OVF_EN defined to also check rsp_ovf.
`timescale 1ns/1ps
module tb_adder_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [31:0]  a_arr [4];
  logic [31:0]  b_arr [4];
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [31:0]  add_in0;
  logic [31:0]  add_in1;
  logic [31:0]  add_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_sum;
  logic [1:0]   rsp_id;
`ifdef ADDER_ARB_OVF_EN
  logic         rsp_ovf;
`endif

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t n;
  int   passed = 0;
  int   total  = 0;

  adder_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ID_WIDTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .add_in0(add_in0),
    .add_in1(add_in1),
    .add_out(add_out),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum),
    .rsp_id(rsp_id)
`ifdef ADDER_ARB_OVF_EN
    ,
    .rsp_ovf(rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  assign add_out = add_in0 + add_in1;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = a_arr[i];
      req_b[i*32 +: 32] = b_arr[i];
    end
  end

  always @(posedge rst) sb.delete();

  // Scoreboard: pop and compare each accepted response, then queue the result of any transfer this cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        total++;
        if (sb.size() == 0) begin
          $display("[TB] FAIL sb_unexpected: got id=%0d sum=%h, required no response", rsp_id, rsp_sum);
        end else begin
          e = sb.pop_front();
`ifdef ADDER_ARB_OVF_EN
          if (rsp_id !== e.id || rsp_sum !== e.sum || rsp_ovf !== e.ovf)
            $display("[TB] FAIL sb_response: got id=%0d sum=%h ovf=%b, required id=%0d sum=%h ovf=%b",
                     rsp_id, rsp_sum, rsp_ovf, e.id, e.sum, e.ovf);
`else
          if (rsp_id !== e.id || rsp_sum !== e.sum)
            $display("[TB] FAIL sb_response: got id=%0d sum=%h, required id=%0d sum=%h",
                     rsp_id, rsp_sum, e.id, e.sum);
`endif
          else
            passed++;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          n.id  = 2'(i);
          n.sum = a_arr[i] + b_arr[i];
          n.ovf = (a_arr[i][31] == b_arr[i][31]) && (n.sum[31] != a_arr[i][31]);
          sb.push_back(n);
        end
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b, required 0", rsp_valid);
    else passed++;
    total++;
    if (rsp_sum !== 32'h0) $display("[TB] FAIL reset_sum: got %h, required 0", rsp_sum);
    else passed++;
    total++;
    if (rsp_id !== 2'd0) $display("[TB] FAIL reset_id: got %0d, required 0", rsp_id);
    else passed++;
    total++;
    if (req_ready !== 4'b0000) $display("[TB] FAIL reset_ready: got %b, required 0000", req_ready);
    else passed++;
`ifdef ADDER_ARB_OVF_EN
    total++;
    if (rsp_ovf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b, required 0", rsp_ovf);
    else passed++;
`endif
    @(posedge clk); #1;
    req_valid = 4'b0000;
    rst       = 1'b0;
  endtask

  task automatic test_single();
    a_arr[1]  = 32'd5;
    b_arr[1]  = 32'd7;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0010) $display("[TB] FAIL single_ready: got %b, required 0010", req_ready);
    else passed++;
    total++;
    if (add_in0 !== 32'd5 || add_in1 !== 32'd7)
      $display("[TB] FAIL single_operands: got %0d,%0d, required 5,7", add_in0, add_in1);
    else passed++;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 32'd12 || rsp_id !== 2'd1)
      $display("[TB] FAIL single_result: got v=%b sum=%0d id=%0d, required v=1 sum=12 id=1",
               rsp_valid, rsp_sum, rsp_id);
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) $display("[TB] FAIL single_drain: got %b, required 0", rsp_valid);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_r;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 32'(100 * (i + 1));
      b_arr[i] = 32'(i);
    end
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_r = 4'b0001 << (k % 4);
      total++;
      if (req_ready !== exp_r) $display("[TB] FAIL rr_grant%0d: got %b, required %b", k, req_ready, exp_r);
      else passed++;
      if (k > 0) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4))
          $display("[TB] FAIL rr_rsp%0d: got v=%b id=%0d, required v=1 id=%0d", k, rsp_valid, rsp_id, (k - 1) % 4);
        else passed++;
      end
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    a_arr[2]  = 32'h0000_1234;
    b_arr[2]  = 32'h0000_1111;
    a_arr[0]  = 32'd1;
    b_arr[0]  = 32'd1;
    a_arr[1]  = 32'd2;
    b_arr[1]  = 32'd2;
    a_arr[3]  = 32'd30;
    b_arr[3]  = 32'd3;
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0100) $display("[TB] FAIL bp_first: got %b, required 0100", req_ready);
    else passed++;
    @(posedge clk); #1;
    req_valid = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_sum !== 32'h0000_2345 || rsp_id !== 2'd2)
        $display("[TB] FAIL bp_hold%0d: got rdy=%b v=%b sum=%h id=%0d, required rdy=0000 v=1 sum=00002345 id=2",
                 k, req_ready, rsp_valid, rsp_sum, rsp_id);
      else passed++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b1000) $display("[TB] FAIL bp_release: got %b, required 1000", req_ready);
    else passed++;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (rsp_id !== 2'd3 || rsp_sum !== 32'd33)
      $display("[TB] FAIL bp_next: got id=%0d sum=%0d, required id=3 sum=33", rsp_id, rsp_sum);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    a_arr[0]  = 32'hFFFF_FFFF;
    b_arr[0]  = 32'h0000_0001;
    req_valid = 4'b0001;
    @(negedge clk);
    @(posedge clk); #1;
    a_arr[0] = 32'h7FFF_FFFF;
    b_arr[0] = 32'h0000_0001;
    @(negedge clk);
    total++;
    if (rsp_sum !== 32'h0) $display("[TB] FAIL wrap_sum: got %h, required 00000000", rsp_sum);
    else passed++;
`ifdef ADDER_ARB_OVF_EN
    total++;
    if (rsp_ovf !== 1'b0) $display("[TB] FAIL wrap_ovf_neg1: got %b, required 0", rsp_ovf);
    else passed++;
`endif
    @(posedge clk); #1;
    a_arr[0] = 32'h8000_0000;
    b_arr[0] = 32'h8000_0000;
    @(negedge clk);
    total++;
    if (rsp_sum !== 32'h8000_0000) $display("[TB] FAIL wrap_pos_sum: got %h, required 80000000", rsp_sum);
    else passed++;
`ifdef ADDER_ARB_OVF_EN
    total++;
    if (rsp_ovf !== 1'b1) $display("[TB] FAIL wrap_ovf_pos: got %b, required 1", rsp_ovf);
    else passed++;
`endif
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (rsp_sum !== 32'h0) $display("[TB] FAIL wrap_neg_sum: got %h, required 00000000", rsp_sum);
    else passed++;
`ifdef ADDER_ARB_OVF_EN
    total++;
    if (rsp_ovf !== 1'b1) $display("[TB] FAIL wrap_ovf_negneg: got %b, required 1", rsp_ovf);
    else passed++;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    a_arr[0]  = 32'd9;
    b_arr[0]  = 32'd9;
    a_arr[1]  = 32'd40;
    b_arr[1]  = 32'd2;
    a_arr[3]  = 32'd50;
    b_arr[3]  = 32'd5;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 4'b1010;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'b0000)
      $display("[TB] FAIL mid_pending: got v=%b rdy=%b, required v=1 rdy=0000", rsp_valid, req_ready);
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 32'h0 || req_ready !== 4'b0000)
      $display("[TB] FAIL mid_reset: got v=%b sum=%h rdy=%b, required v=0 sum=0 rdy=0000",
               rsp_valid, rsp_sum, req_ready);
    else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0010) $display("[TB] FAIL mid_first_grant: got %b, required 0010", req_ready);
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rsp_id !== 2'd1 || rsp_sum !== 32'd42 || req_ready !== 4'b1000)
      $display("[TB] FAIL mid_second: got id=%0d sum=%0d rdy=%b, required id=1 sum=42 rdy=1000",
               rsp_id, rsp_sum, req_ready);
    else passed++;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_idle_gaps();
    do_reset();
    rsp_ready = 1'b1;
    a_arr[0]  = 32'd1;
    b_arr[0]  = 32'd1;
    a_arr[3]  = 32'd3;
    b_arr[3]  = 32'd3;
    req_valid = 4'b1000;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b1000) $display("[TB] FAIL idle_g1: got %b, required 1000", req_ready);
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b1000) $display("[TB] FAIL idle_g2: got %b, required 1000", req_ready);
    else passed++;
    @(posedge clk); #1;
    req_valid = 4'b1001;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) $display("[TB] FAIL idle_g3: got %b, required 0001", req_ready);
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b1000) $display("[TB] FAIL idle_g4: got %b, required 1000", req_ready);
    else passed++;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 32'h0;
      b_arr[i] = 32'h0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_idle_gaps();
    total++;
    if (sb.size() != 0) $display("[TB] FAIL sb_leftover: got %0d pending, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
